pcm_cpu_mem_bridge: RTL and testbench
=====================================

Name: pcm_cpu_mem_bridge

Overview:
Bridges the 16-bit soft CPU's async-SRAM-style memory strobes onto the exported PCM shared-memory port of the Nios system (the on-chip RAM second port). Arbitrates buffer ownership between the Nios and the CPU through the 4-bit ctl/rsp PIO handshake. Stalls the CPU while the Nios owns the buffer or a RAM access is in flight.

Parameters:
ADDR_W, 11, RAM word-address width (mem_address)
DATA_W, 16, data width; must be 16 (two byte lanes)
RD_LAT, 1, RAM read latency in clocks (1..3)
WIN_BASE, 20'h00000, CPU base address of the RAM window (low ADDR_W bits zero)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-low reset
cpu_addr  in  20  CPU word address
cpu_ce_n / cpu_ub_n / cpu_lb_n / cpu_oe_n / cpu_we_n  in  1 each  CPU strobes, active-low
cpu_wdata  in  16  CPU write data (top level resolves the tristate)
cpu_rdata  out  16  registered read data
cpu_rdata_oe  out  1  top level drives the CPU data bus with cpu_rdata
cpu_ready  out  1  1 = access complete / not stalled
mem_address  out  ADDR_W  RAM word address
mem_chipselect / mem_clken / mem_write  out  1 each  RAM controls
mem_writedata  out  16  RAM write data
mem_byteenable  out  2  {UB,LB} active-high
mem_readdata  in  16  RAM read data
ctl_in  in  4  from Nios PIO: [0] grant-to-CPU, [1] release-request, [3:2] reserved
rsp_out  out  4  to Nios PIO: [0] cpu_owns, [1] release_ack, [2] window_err, [3] busy

Behaviour:
- Reset values: all mem_* 0, cpu_rdata 0, cpu_rdata_oe 0, cpu_ready 0, rsp_out 0, FSM = NIOS_OWN.
- access = ~cpu_ce_n & (~cpu_oe_n | ~cpu_we_n). start = access & (no access last cycle | cpu_addr or strobe set changed). All CPU inputs are registered once before use.
- States:
  - NIOS_OWN: cpu_ready=0. ctl_in[0] rising edge -> CPU_IDLE.
  - CPU_IDLE: rsp_out[0]=1, cpu_ready=1. start with we_n=0 -> WRITE. start with oe_n=0 and we_n=1 -> READ. ctl_in[1]=1 with no start -> RELEASE.
  - WRITE: exactly one cycle of chipselect=clken=write=1, address=cpu_addr[ADDR_W-1:0], byteenable={~ub_n,~lb_n}; cpu_ready=0; next CPU_IDLE.
  - READ: chipselect=clken=1, write=0, held for RD_LAT cycles. On the last cycle, latch mem_readdata into cpu_rdata; cpu_ready=0 until then; next CPU_IDLE.
  - RELEASE: rsp_out[1]=1 and rsp_out[0]=0 until ctl_in[1] falls, then NIOS_OWN.
- cpu_rdata_oe = 1 in CPU_IDLE while ~ce_n & ~oe_n & we_n and the last completed op was a read of the current address; otherwise 0.
- rsp_out[3] = 1 in WRITE or READ.
- Boundary cases:
  - oe_n and we_n both low: treated as a write.
  - ub_n and lb_n both high: no RAM op; cpu_ready stays 1.
  - Release request during WRITE/READ: the op completes, then RELEASE.
  - ctl_in[0] and ctl_in[1] both set in NIOS_OWN: grant ignored.
  - Access while NIOS_OWN: held stalled and issued on grant.
- Asynchronous reset mid-op: mem_write deasserts immediately. A partial read is discarded.
- Address wraps modulo 2^ADDR_W.

Optional Feature:
PCM_BRIDGE_PROT_EN:
- Defined: accesses with cpu_addr[19:ADDR_W] != WIN_BASE[19:ADDR_W] issue no RAM op. Reads return 16'hDEAD. cpu_ready stays 1. rsp_out[2] is set sticky and cleared on entry to NIOS_OWN.
- Undefined: upper address bits are ignored and rsp_out[2] is tied 0.

Test Plan:
- Reset with ctl_in=0, CPU write attempt -> cpu_ready=0, mem_write never 1, rsp_out=4'b0000.
- ctl_in[0] 0->1, CPU write addr 20'h00005 data 16'hA55A, ub_n=lb_n=0 -> one-cycle mem_write, address 11'h005, byteenable 2'b11, cpu_ready low 1 cycle, rsp_out[3] high that cycle.
- Read addr 20'h00005 with RD_LAT=2, RAM returns 16'hA55A -> cpu_ready low 2 cycles, cpu_rdata=16'hA55A, cpu_rdata_oe=1.
- Write with lb_n=0, ub_n=1, data 16'h1234 -> byteenable 2'b01; then both ub_n and lb_n high -> no mem op.
- ctl_in[1] asserted mid-read -> read completes, rsp_out=4'b0010, ctl_in[1] drop -> NIOS_OWN, rsp_out=0.
- PCM_BRIDGE_PROT_EN defined, read 20'h10000 -> cpu_rdata=16'hDEAD, no chipselect, rsp_out[2]=1 until release.

Source files
------------

// File: rtl/pcm_cpu_mem_bridge.sv
// Bridges the soft CPU's async-SRAM strobes onto the Nios PCM shared-RAM port with PIO ownership handshake.
// Optional window protection: define PCM_BRIDGE_PROT_EN.
module pcm_cpu_mem_bridge #(
   parameter int unsigned ADDR_W   = 11,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned RD_LAT   = 1,
   parameter logic [19:0] WIN_BASE = 20'h00000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [19:0]       cpu_addr,
   input  logic              cpu_ce_n,
   input  logic              cpu_ub_n,
   input  logic              cpu_lb_n,
   input  logic              cpu_oe_n,
   input  logic              cpu_we_n,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rdata_oe,
   output logic              cpu_ready,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_chipselect,
   output logic              mem_clken,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic [1:0]        mem_byteenable,
   input  logic [DATA_W-1:0] mem_readdata,
   input  logic [3:0]        ctl_in,
   output logic [3:0]        rsp_out
);

   localparam int unsigned CPU_AW = 20;
   localparam int unsigned CNT_W  = 2;
   localparam int unsigned STRB_W = 5;

   typedef enum logic [2:0] {
      NIOS_OWN = 3'd0,
      CPU_IDLE = 3'd1,
      WRITE    = 3'd2,
      READ     = 3'd3,
      RELEASE  = 3'd4
   } state_t;

   state_t state, state_nx;

   logic [CPU_AW-1:0] addr_q;
   logic              ce_n_q, ub_n_q, lb_n_q, oe_n_q, we_n_q;
   logic [DATA_W-1:0] wdata_q;
   logic [1:0]        ctl_q, ctl_prev;

   logic [CPU_AW-1:0] last_addr;
   logic [STRB_W-1:0] last_strb;
   logic              access_last;

   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic              pend, pend_nx;
   logic              rd_valid, rd_valid_nx;
   logic [CPU_AW-1:0] rd_addr, rd_addr_nx;
   logic              err, err_nx;

   logic [DATA_W-1:0] rdata_nx;
   logic              rdata_oe_nx, ready_nx;
   logic [ADDR_W-1:0] mem_address_nx;
   logic              mem_cs_nx, mem_write_nx;
   logic [DATA_W-1:0] mem_writedata_nx;
   logic [1:0]        mem_be_nx;
   logic [3:0]        rsp_nx;

   logic [STRB_W-1:0] strb_q;
   logic              access, start, req, take, no_lanes, is_wr, win_miss, busy_nx;
   logic [ADDR_W-1:0] win_off;

   // Reserved PIO control bits carry no function.
   logic unused_ctl;
   assign unused_ctl = &{1'b0, ctl_in[3:2]};

   // Single register stage on all CPU and PIO inputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q   <= '0;
         ce_n_q   <= 1'b1;
         ub_n_q   <= 1'b1;
         lb_n_q   <= 1'b1;
         oe_n_q   <= 1'b1;
         we_n_q   <= 1'b1;
         wdata_q  <= '0;
         ctl_q    <= '0;
         ctl_prev <= '0;
      end else begin
         addr_q   <= cpu_addr;
         ce_n_q   <= cpu_ce_n;
         ub_n_q   <= cpu_ub_n;
         lb_n_q   <= cpu_lb_n;
         oe_n_q   <= cpu_oe_n;
         we_n_q   <= cpu_we_n;
         wdata_q  <= cpu_wdata;
         ctl_q    <= ctl_in[1:0];
         ctl_prev <= ctl_q;
      end
   end

   assign strb_q   = {ce_n_q, ub_n_q, lb_n_q, oe_n_q, we_n_q};
   assign access   = ~ce_n_q & (~oe_n_q | ~we_n_q);
   assign start    = access & (~access_last | (addr_q != last_addr) | (strb_q != last_strb));
   assign req      = start | pend;
   assign is_wr    = ~we_n_q;
   assign no_lanes = ub_n_q & lb_n_q;
   assign win_off  = addr_q[ADDR_W-1:0] - WIN_BASE[ADDR_W-1:0];

`ifdef PCM_BRIDGE_PROT_EN
   assign win_miss = (addr_q[CPU_AW-1:ADDR_W] != WIN_BASE[CPU_AW-1:ADDR_W]);
`else
   assign win_miss = 1'b0;
`endif

   // Next-state, bookkeeping and next registered outputs.
   always_comb begin
      state_nx         = state;
      cnt_nx           = cnt;
      rd_valid_nx      = rd_valid;
      rd_addr_nx       = rd_addr;
      err_nx           = err;
      rdata_nx         = cpu_rdata;
      mem_address_nx   = mem_address;
      mem_writedata_nx = mem_writedata;
      mem_be_nx        = mem_byteenable;
      take             = 1'b0;

      case (state)
         NIOS_OWN: begin
            if (ctl_q[0] & ~ctl_prev[0] & ~ctl_q[1]) state_nx = CPU_IDLE;
         end
         CPU_IDLE: begin
            if (req) begin
               take = 1'b1;
               if (no_lanes) begin
                  rd_valid_nx = 1'b0;
               end else if (win_miss) begin
                  err_nx = 1'b1;
                  if (is_wr) begin
                     rd_valid_nx = 1'b0;
                  end else begin
                     rdata_nx    = DATA_W'(16'hDEAD);
                     rd_valid_nx = 1'b1;
                     rd_addr_nx  = addr_q;
                  end
               end else begin
                  mem_address_nx = win_off;
                  mem_be_nx      = {~ub_n_q, ~lb_n_q};
                  rd_valid_nx    = 1'b0;
                  if (is_wr) begin
                     mem_writedata_nx = wdata_q;
                     state_nx         = WRITE;
                  end else begin
                     cnt_nx     = '0;
                     rd_addr_nx = addr_q;
                     state_nx   = READ;
                  end
               end
            end else if (ctl_q[1]) begin
               state_nx = RELEASE;
            end
         end
         WRITE: begin
            state_nx = CPU_IDLE;
         end
         READ: begin
            if (cnt == CNT_W'(RD_LAT - 1)) begin
               rdata_nx    = mem_readdata;
               rd_valid_nx = 1'b1;
               state_nx    = CPU_IDLE;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         RELEASE: begin
            if (!ctl_q[1]) state_nx = NIOS_OWN;
         end
         default: begin
            state_nx = NIOS_OWN;
         end
      endcase

      // Handing the buffer back to the Nios clears the error flag and the read cache.
      if (state_nx == NIOS_OWN) begin
         err_nx      = 1'b0;
         rd_valid_nx = 1'b0;
      end

      pend_nx      = access & req & ~take;
      busy_nx      = (state_nx == WRITE) || (state_nx == READ);
      mem_cs_nx    = busy_nx;
      mem_write_nx = (state_nx == WRITE);
      if (!busy_nx) mem_be_nx = '0;
      ready_nx     = (state_nx == CPU_IDLE);
      rdata_oe_nx  = (state_nx == CPU_IDLE) & rd_valid_nx & ~ce_n_q & ~oe_n_q & we_n_q &
                     (addr_q == rd_addr_nx);
      rsp_nx       = {busy_nx, err_nx, state_nx == RELEASE,
                      state_nx inside {CPU_IDLE, WRITE, READ}};
   end

   // State, bookkeeping and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state          <= NIOS_OWN;
         cnt            <= '0;
         pend           <= 1'b0;
         rd_valid       <= 1'b0;
         rd_addr        <= '0;
         err            <= 1'b0;
         access_last    <= 1'b0;
         last_addr      <= '0;
         last_strb      <= '1;
         cpu_rdata      <= '0;
         cpu_rdata_oe   <= 1'b0;
         cpu_ready      <= 1'b0;
         mem_address    <= '0;
         mem_chipselect <= 1'b0;
         mem_clken      <= 1'b0;
         mem_write      <= 1'b0;
         mem_writedata  <= '0;
         mem_byteenable <= '0;
         rsp_out        <= '0;
      end else begin
         state          <= state_nx;
         cnt            <= cnt_nx;
         pend           <= pend_nx;
         rd_valid       <= rd_valid_nx;
         rd_addr        <= rd_addr_nx;
         err            <= err_nx;
         access_last    <= access;
         last_addr      <= addr_q;
         last_strb      <= strb_q;
         cpu_rdata      <= rdata_nx;
         cpu_rdata_oe   <= rdata_oe_nx;
         cpu_ready      <= ready_nx;
         mem_address    <= mem_address_nx;
         mem_chipselect <= mem_cs_nx;
         mem_clken      <= mem_cs_nx;
         mem_write      <= mem_write_nx;
         mem_writedata  <= mem_writedata_nx;
         mem_byteenable <= mem_be_nx;
         rsp_out        <= rsp_nx;
      end
   end

endmodule

// File: tb/tb_pcm_cpu_mem_bridge.sv
// Self-checking bench for pcm_cpu_mem_bridge: scenario tasks plus randomized traffic against a word/byte-lane memory model.
module tb_pcm_cpu_mem_bridge;

   localparam int unsigned ADDR_W = 11;
   localparam int unsigned RD_LAT = 2;

   logic              clk;
   logic              reset;
   logic [19:0]       cpu_addr;
   logic              cpu_ce_n, cpu_ub_n, cpu_lb_n, cpu_oe_n, cpu_we_n;
   logic [15:0]       cpu_wdata;
   logic [15:0]       cpu_rdata;
   logic              cpu_rdata_oe;
   logic              cpu_ready;
   logic [ADDR_W-1:0] mem_address;
   logic              mem_chipselect, mem_clken, mem_write;
   logic [15:0]       mem_writedata;
   logic [1:0]        mem_byteenable;
   logic [15:0]       mem_readdata;
   logic [3:0]        ctl_in;
   logic [3:0]        rsp_out;

   int n_checks = 0;
   int n_fail   = 0;

   pcm_cpu_mem_bridge #(
      .ADDR_W(ADDR_W), .DATA_W(16), .RD_LAT(RD_LAT), .WIN_BASE(20'h00000)
   ) dut (
      .clk(clk), .reset(reset), .cpu_addr(cpu_addr),
      .cpu_ce_n(cpu_ce_n), .cpu_ub_n(cpu_ub_n), .cpu_lb_n(cpu_lb_n),
      .cpu_oe_n(cpu_oe_n), .cpu_we_n(cpu_we_n), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_rdata_oe(cpu_rdata_oe), .cpu_ready(cpu_ready),
      .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_clken(mem_clken),
      .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
      .mem_readdata(mem_readdata), .ctl_in(ctl_in), .rsp_out(rsp_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // On-chip RAM stand-in (registered read port).
   logic [15:0] ram [0:2047];
   always @(posedge clk) begin
      if (mem_chipselect && mem_clken) begin
         if (mem_write) begin
            if (mem_byteenable[0]) ram[mem_address][7:0]  <= mem_writedata[7:0];
            if (mem_byteenable[1]) ram[mem_address][15:8] <= mem_writedata[15:8];
         end
         mem_readdata <= ram[mem_address];
      end
   end

   // Bus monitor: counts RAM cycles and remembers the last write.
   int          wr_cnt = 0;
   int          cs_cnt = 0;
   logic [10:0] wr_addr_l;
   logic [1:0]  wr_be_l;
   logic [15:0] wr_data_l;
   always @(negedge clk) begin
      if (mem_chipselect) cs_cnt++;
      if (mem_write) begin
         wr_cnt++;
         wr_addr_l = mem_address;
         wr_be_l   = mem_byteenable;
         wr_data_l = mem_writedata;
      end
   end

   // Reference memory contents seen by the CPU.
   logic [15:0] model [0:2047];

   function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d,
                                         input logic ub_n, input logic lb_n);
      logic [15:0] r;
      r = old;
      if (!lb_n) r[7:0]  = d[7:0];
      if (!ub_n) r[15:8] = d[15:8];
      return r;
   endfunction

   task automatic idle(input int n);
      cpu_ce_n = 1'b1; cpu_oe_n = 1'b1; cpu_we_n = 1'b1;
      cpu_ub_n = 1'b1; cpu_lb_n = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // Hold one CPU access for a fixed window, counting stall and busy cycles.
   task automatic do_access(input logic we_n, input logic oe_n, input logic [19:0] a,
                            input logic [15:0] d, input logic ub_n, input logic lb_n,
                            input int win, output int stall, output int busy,
                            output int nwr, output int ncs);
      int w0, c0;
      w0 = wr_cnt; c0 = cs_cnt; stall = 0; busy = 0;
      cpu_addr = a; cpu_wdata = d; cpu_ce_n = 1'b0;
      cpu_ub_n = ub_n; cpu_lb_n = lb_n; cpu_we_n = we_n; cpu_oe_n = oe_n;
      repeat (win) begin
         @(negedge clk);
         if (!cpu_ready) stall++;
         if (rsp_out[3]) busy++;
      end
      nwr = wr_cnt - w0;
      ncs = cs_cnt - c0;
   endtask

   task automatic test_reset;
      int stall, busy, nwr, ncs;
      reset = 1'b0; ctl_in = 4'h0; cpu_addr = '0; cpu_wdata = '0;
      cpu_ce_n = 1'b1; cpu_oe_n = 1'b1; cpu_we_n = 1'b1; cpu_ub_n = 1'b1; cpu_lb_n = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0", cpu_ready); end
      n_checks++; if (rsp_out !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp got %b want 0000", rsp_out); end
      n_checks++; if ({mem_chipselect, mem_clken, mem_write, mem_byteenable} !== 5'b0)
         begin n_fail++; $display("FAIL reset_mem got %b want 00000", {mem_chipselect, mem_clken, mem_write, mem_byteenable}); end
      n_checks++; if ({cpu_rdata, cpu_rdata_oe} !== 17'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", {cpu_rdata, cpu_rdata_oe}); end
      reset = 1'b1;
      @(negedge clk);
      do_access(1'b0, 1'b1, 20'h00005, 16'hA55A, 1'b0, 1'b0, 8, stall, busy, nwr, ncs);
      n_checks++; if (stall !== 8) begin n_fail++; $display("FAIL nios_own_stall got %0d want 8", stall); end
      n_checks++; if (nwr !== 0) begin n_fail++; $display("FAIL nios_own_nwr got %0d want 0", nwr); end
      n_checks++; if (rsp_out !== 4'b0000) begin n_fail++; $display("FAIL nios_own_rsp got %b want 0000", rsp_out); end
   endtask

   task automatic test_grant_pending;
      int w0;
      w0 = wr_cnt;
      ctl_in = 4'b0001;
      repeat (8) @(negedge clk);
      n_checks++; if (wr_cnt - w0 !== 1) begin n_fail++; $display("FAIL grant_issue nwr got %0d want 1", wr_cnt - w0); end
      n_checks++; if ({wr_addr_l, wr_be_l, wr_data_l} !== {11'h005, 2'b11, 16'hA55A})
         begin n_fail++; $display("FAIL grant_wr got %h/%b/%h want 005/11/a55a", wr_addr_l, wr_be_l, wr_data_l); end
      n_checks++; if (rsp_out !== 4'b0001) begin n_fail++; $display("FAIL grant_rsp got %b want 0001", rsp_out); end
      model[11'h005] = 16'hA55A;
      idle(2);
   endtask

   task automatic test_write;
      int stall, busy, nwr, ncs;
      do_access(1'b0, 1'b1, 20'h00005, 16'hA55A, 1'b0, 1'b0, 8, stall, busy, nwr, ncs);
      n_checks++; if (stall !== 1) begin n_fail++; $display("FAIL write_stall got %0d want 1", stall); end
      n_checks++; if (busy !== 1) begin n_fail++; $display("FAIL write_busy got %0d want 1", busy); end
      n_checks++; if (nwr !== 1 || wr_addr_l !== 11'h005 || wr_be_l !== 2'b11)
         begin n_fail++; $display("FAIL write_bus got n=%0d a=%h be=%b want 1/005/11", nwr, wr_addr_l, wr_be_l); end
      model[11'h005] = 16'hA55A;
      idle(2);
   endtask

   task automatic test_read;
      int stall, busy, nwr, ncs;
      do_access(1'b1, 1'b0, 20'h00005, 16'h0000, 1'b0, 1'b0, 8, stall, busy, nwr, ncs);
      n_checks++; if (stall !== RD_LAT) begin n_fail++; $display("FAIL read_stall got %0d want %0d", stall, RD_LAT); end
      n_checks++; if (ncs !== RD_LAT || nwr !== 0) begin n_fail++; $display("FAIL read_cs got cs=%0d wr=%0d want %0d/0", ncs, nwr, RD_LAT); end
      n_checks++; if (cpu_rdata !== model[11'h005]) begin n_fail++; $display("FAIL read_data got %h want %h", cpu_rdata, model[11'h005]); end
      n_checks++; if (cpu_rdata_oe !== 1'b1) begin n_fail++; $display("FAIL read_oe got %b want 1", cpu_rdata_oe); end
      idle(3);
      n_checks++; if (cpu_rdata_oe !== 1'b0) begin n_fail++; $display("FAIL read_oe_off got %b want 0", cpu_rdata_oe); end
   endtask

   task automatic test_byte_lanes;
      int stall, busy, nwr, ncs;
      do_access(1'b0, 1'b1, 20'h00005, 16'h1234, 1'b1, 1'b0, 8, stall, busy, nwr, ncs);
      n_checks++; if (nwr !== 1 || wr_be_l !== 2'b01 || wr_data_l !== 16'h1234)
         begin n_fail++; $display("FAIL lane_lo got n=%0d be=%b d=%h want 1/01/1234", nwr, wr_be_l, wr_data_l); end
      model[11'h005] = merge(model[11'h005], 16'h1234, 1'b1, 1'b0);
      idle(2);
      do_access(1'b0, 1'b1, 20'h00005, 16'hFFFF, 1'b1, 1'b1, 8, stall, busy, nwr, ncs);
      n_checks++; if (nwr !== 0 || ncs !== 0 || stall !== 0)
         begin n_fail++; $display("FAIL lane_none got wr=%0d cs=%0d stall=%0d want 0/0/0", nwr, ncs, stall); end
      idle(2);
      do_access(1'b1, 1'b0, 20'h00005, 16'h0000, 1'b0, 1'b0, 8, stall, busy, nwr, ncs);
      n_checks++; if (cpu_rdata !== model[11'h005]) begin n_fail++; $display("FAIL lane_readback got %h want %h", cpu_rdata, model[11'h005]); end
      idle(2);
   endtask

   task automatic test_oe_we_both_low;
      int stall, busy, nwr, ncs;
      do_access(1'b0, 1'b0, 20'h00006, 16'h5EED, 1'b0, 1'b0, 8, stall, busy, nwr, ncs);
      n_checks++; if (nwr !== 1 || wr_addr_l !== 11'h006 || wr_data_l !== 16'h5EED || cpu_rdata_oe !== 1'b0)
         begin n_fail++; $display("FAIL both_low got n=%0d a=%h d=%h oe=%b want 1/006/5eed/0", nwr, wr_addr_l, wr_data_l, cpu_rdata_oe); end
      model[11'h006] = 16'h5EED;
      idle(2);
   endtask

   task automatic test_back_to_back;
      int stall, busy, nwr, ncs;
      do_access(1'b0, 1'b1, 20'h00007, 16'h0707, 1'b0, 1'b0, 6, stall, busy, nwr, ncs);
      model[11'h007] = 16'h0707;
      do_access(1'b0, 1'b1, 20'h00008, 16'h0808, 1'b0, 1'b0, 6, stall, busy, nwr, ncs);
      n_checks++; if (nwr !== 1 || stall !== 1 || wr_addr_l !== 11'h008)
         begin n_fail++; $display("FAIL b2b_write got n=%0d stall=%0d a=%h want 1/1/008", nwr, stall, wr_addr_l); end
      model[11'h008] = 16'h0808;
      do_access(1'b1, 1'b0, 20'h00007, 16'h0000, 1'b0, 1'b0, 6, stall, busy, nwr, ncs);
      n_checks++; if (cpu_rdata !== model[11'h007]) begin n_fail++; $display("FAIL b2b_read7 got %h want %h", cpu_rdata, model[11'h007]); end
      do_access(1'b1, 1'b0, 20'h00008, 16'h0000, 1'b0, 1'b0, 6, stall, busy, nwr, ncs);
      n_checks++; if (cpu_rdata !== model[11'h008] || stall !== RD_LAT || cpu_rdata_oe !== 1'b1)
         begin n_fail++; $display("FAIL b2b_read8 got %h stall=%0d oe=%b want %h/%0d/1", cpu_rdata, stall, cpu_rdata_oe, model[11'h008], RD_LAT); end
      idle(2);
   endtask

   task automatic test_random;
      int stall, busy, nwr, ncs, kind, k;
      logic [10:0] tab [0:7];
      logic [10:0] idx;
      logic [8:0]  up;
      logic [15:0] d;
      logic        ub_n, lb_n;
      for (int i = 0; i < 8; i++) begin
         tab[i] = 11'($urandom_range(16, 2047));
         d = 16'($urandom);
         do_access(1'b0, 1'b1, {9'h000, tab[i]}, d, 1'b0, 1'b0, 5, stall, busy, nwr, ncs);
         model[tab[i]] = d;
         idle(2);
      end
      for (int i = 0; i < 40; i++) begin
         k    = $urandom_range(0, 7);
         idx  = tab[k];
`ifdef PCM_BRIDGE_PROT_EN
         up   = 9'h000;
`else
         up   = 9'($urandom);
`endif
         kind = $urandom_range(0, 1);
         d    = 16'($urandom);
         ub_n = 1'($urandom_range(0, 1));
         lb_n = 1'($urandom_range(0, 1));
         if (kind == 0) begin
            do_access(1'b0, 1'b1, {up, idx}, d, ub_n, lb_n, 6, stall, busy, nwr, ncs);
            if (ub_n && lb_n) begin
               n_checks++; if (nwr !== 0 || stall !== 0) begin n_fail++; $display("FAIL rnd_wr_nolane got n=%0d stall=%0d want 0/0", nwr, stall); end
            end else begin
               n_checks++; if (nwr !== 1 || stall !== 1 || wr_addr_l !== idx || wr_be_l !== {~ub_n, ~lb_n} || wr_data_l !== d)
                  begin n_fail++; $display("FAIL rnd_wr got n=%0d stall=%0d a=%h be=%b d=%h want 1/1/%h/%b/%h",
                        nwr, stall, wr_addr_l, wr_be_l, wr_data_l, idx, {~ub_n, ~lb_n}, d); end
               model[idx] = merge(model[idx], d, ub_n, lb_n);
            end
         end else begin
            do_access(1'b1, 1'b0, {up, idx}, 16'h0000, ub_n, lb_n, 6, stall, busy, nwr, ncs);
            if (ub_n && lb_n) begin
               n_checks++; if (ncs !== 0 || stall !== 0) begin n_fail++; $display("FAIL rnd_rd_nolane got cs=%0d stall=%0d want 0/0", ncs, stall); end
            end else begin
               n_checks++; if (cpu_rdata !== model[idx] || stall !== RD_LAT || cpu_rdata_oe !== 1'b1)
                  begin n_fail++; $display("FAIL rnd_rd got %h stall=%0d oe=%b want %h/%0d/1", cpu_rdata, stall, cpu_rdata_oe, model[idx], RD_LAT); end
            end
         end
         idle(2);
      end
   endtask

   task automatic test_release;
      cpu_addr = 20'h00007; cpu_ce_n = 1'b0; cpu_oe_n = 1'b0; cpu_we_n = 1'b1;
      cpu_ub_n = 1'b0; cpu_lb_n = 1'b0;
      repeat (2) @(negedge clk);
      ctl_in = 4'b0011;
      repeat (6) @(negedge clk);
      n_checks++; if (cpu_rdata !== model[11'h007]) begin n_fail++; $display("FAIL rel_read got %h want %h", cpu_rdata, model[11'h007]); end
      n_checks++; if (rsp_out !== 4'b0010 || cpu_ready !== 1'b0)
         begin n_fail++; $display("FAIL rel_rsp got %b ready=%b want 0010/0", rsp_out, cpu_ready); end
      ctl_in = 4'b0001;
      repeat (4) @(negedge clk);
      n_checks++; if (rsp_out !== 4'b0000) begin n_fail++; $display("FAIL rel_done got %b want 0000", rsp_out); end
      idle(2);
   endtask

   task automatic test_both_ctl;
      ctl_in = 4'b0000;
      repeat (3) @(negedge clk);
      ctl_in = 4'b0011;
      repeat (4) @(negedge clk);
      n_checks++; if (rsp_out !== 4'b0000 || cpu_ready !== 1'b0)
         begin n_fail++; $display("FAIL both_ctl got %b ready=%b want 0000/0", rsp_out, cpu_ready); end
      ctl_in = 4'b0001;
      repeat (4) @(negedge clk);
      n_checks++; if (rsp_out !== 4'b0000) begin n_fail++; $display("FAIL held_grant got %b want 0000", rsp_out); end
      ctl_in = 4'b0000;
      repeat (2) @(negedge clk);
      ctl_in = 4'b0001;
      repeat (4) @(negedge clk);
      n_checks++; if (rsp_out !== 4'b0001 || cpu_ready !== 1'b1)
         begin n_fail++; $display("FAIL regrant got %b ready=%b want 0001/1", rsp_out, cpu_ready); end
   endtask

`ifdef PCM_BRIDGE_PROT_EN
   task automatic test_prot;
      int stall, busy, nwr, ncs;
      do_access(1'b1, 1'b0, 20'h10000, 16'h0000, 1'b0, 1'b0, 6, stall, busy, nwr, ncs);
      n_checks++; if (cpu_rdata !== 16'hDEAD || ncs !== 0 || stall !== 0)
         begin n_fail++; $display("FAIL prot_read got %h cs=%0d stall=%0d want dead/0/0", cpu_rdata, ncs, stall); end
      n_checks++; if (rsp_out !== 4'b0101) begin n_fail++; $display("FAIL prot_err got %b want 0101", rsp_out); end
      idle(2);
      do_access(1'b0, 1'b1, 20'h10005, 16'hBAD0, 1'b0, 1'b0, 6, stall, busy, nwr, ncs);
      n_checks++; if (nwr !== 0 || stall !== 0) begin n_fail++; $display("FAIL prot_write got n=%0d stall=%0d want 0/0", nwr, stall); end
      idle(2);
      ctl_in = 4'b0011;
      repeat (4) @(negedge clk);
      n_checks++; if (rsp_out !== 4'b0110) begin n_fail++; $display("FAIL prot_rel got %b want 0110", rsp_out); end
      ctl_in = 4'b0000;
      repeat (4) @(negedge clk);
      n_checks++; if (rsp_out !== 4'b0000) begin n_fail++; $display("FAIL prot_clear got %b want 0000", rsp_out); end
      ctl_in = 4'b0001;
      repeat (4) @(negedge clk);
   endtask
`endif

   task automatic test_reset_mid_op;
      cpu_addr = 20'h00100; cpu_wdata = 16'hBEEF; cpu_ce_n = 1'b0;
      cpu_oe_n = 1'b1; cpu_we_n = 1'b0; cpu_ub_n = 1'b0; cpu_lb_n = 1'b0;
      repeat (2) @(negedge clk);
      n_checks++; if (mem_write !== 1'b1) begin n_fail++; $display("FAIL mid_wr_active got %b want 1", mem_write); end
      reset = 1'b0;
      #1;
      n_checks++; if (mem_write !== 1'b0 || mem_chipselect !== 1'b0)
         begin n_fail++; $display("FAIL mid_wr_abort got w=%b cs=%b want 0/0", mem_write, mem_chipselect); end
      idle(1);
      reset = 1'b1;
      repeat (4) @(negedge clk);
      n_checks++; if (rsp_out !== 4'b0001) begin n_fail++; $display("FAIL post_reset_grant got %b want 0001", rsp_out); end
      cpu_addr = 20'h00005; cpu_ce_n = 1'b0; cpu_oe_n = 1'b0; cpu_we_n = 1'b1;
      cpu_ub_n = 1'b0; cpu_lb_n = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      idle(1);
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_checks++; if (cpu_rdata !== 16'h0000 || cpu_rdata_oe !== 1'b0)
         begin n_fail++; $display("FAIL mid_rd_discard got %h oe=%b want 0000/0", cpu_rdata, cpu_rdata_oe); end
   endtask

   initial begin
      test_reset();
      test_grant_pending();
      test_write();
      test_read();
      test_byte_lanes();
      test_oe_we_both_low();
      test_back_to_back();
      test_random();
      test_release();
      test_both_ctl();
`ifdef PCM_BRIDGE_PROT_EN
      test_prot();
`endif
      test_reset_mid_op();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
